inst_sram_resp: RTL and testbench

//  Responder end of the fetch-side SRAM interface (en/wen/addr/wdata -> rdata) driven by the IF stage.

---
 rtl/inst_sram_resp_pkg.sv | 27 ++
 rtl/inst_sram_resp_if.sv | 27 ++
 rtl/inst_sram_resp_sram_bank.sv | 40 ++++
 rtl/inst_sram_resp.sv | 107 ++++++++++
 tb/tb_inst_sram_resp.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/inst_sram_resp_pkg.sv
// ============================================================================
// Module  : inst_sram_resp_pkg
// Brief   : Shared constants and types for the instruction SRAM responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package inst_sram_resp_pkg;

  localparam logic [31:0] c_INST_RESET_PC = 32'h1c000000;
  localparam logic [31:0] c_NOP_INST      = 32'h03400000;

  // Selects what drives rdata; the bank register itself holds the last word.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_BANK = 2'd1,
    SRC_OOB  = 2'd2
  } rsrc_e;

  function automatic logic [31:0] addr_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_sram_resp_if.sv
// ============================================================================
// Module  : inst_sram_resp_if
// Brief   : Fetch-side SRAM bus between the IF stage and the memory responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface inst_sram_resp_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_rvalid;

  modport master (
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata, inst_sram_rvalid
  );

  modport slave (
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata, inst_sram_rvalid
  );
endinterface

`default_nettype wire

// File: rtl/inst_sram_resp_sram_bank.sv
// ============================================================================
// Module  : sram_bank
// Brief   : DEPTH x 32 array, byte-lane write port, registered read-first read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_bank #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic          clk,
  input  wire logic [3:0]    i_we,
  input  wire logic [AW-1:0] i_waddr,
  input  wire logic [31:0]   i_wdata,
  input  wire logic          i_re,
  input  wire logic [AW-1:0] i_raddr,
  output logic      [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Non-blocking read and write in one block gives read-first on a collision.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
    for (int k = 0; k < 4; k++) begin
      if (i_we[k]) begin
        r_mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/inst_sram_resp.sv
// ============================================================================
// Module  : inst_sram_resp
// Brief   : Instruction SRAM responder: 1-cycle reads, byte writes, loader port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inst_sram_resp
  import inst_sram_resp_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = c_INST_RESET_PC,
  parameter logic [31:0] OOB_INST  = c_NOP_INST
) (
  input  wire logic        clk,
  input  wire logic        reset,
  inst_sram_resp_if.slave  bus,
  output logic             oob_err,
  input  wire logic        load_en,
  input  wire logic [31:0] load_addr,
  input  wire logic [31:0] load_data
);

  localparam int          c_AW   = $clog2(DEPTH);
  localparam logic [31:0] c_SPAN = 32'(4 * DEPTH);

  logic [31:0]     w_cpu_off;
  logic [31:0]     w_load_off;
  logic            w_cpu_in;
  logic            w_load_in;
  logic            w_accept;
  logic [c_AW-1:0] w_cpu_idx;
  logic [c_AW-1:0] w_load_idx;
  logic [3:0]      w_we;
  logic [c_AW-1:0] w_waddr;
  logic [31:0]     w_wdata;
  logic [31:0]     w_bank_rdata;

  rsrc_e r_src;
  logic  r_rvalid;
  logic  r_oob_err;

  assign w_cpu_off  = addr_offset(bus.inst_sram_addr, BASE_ADDR);
  assign w_load_off = addr_offset(load_addr, BASE_ADDR);
  assign w_cpu_in   = (w_cpu_off < c_SPAN);
  assign w_load_in  = (w_load_off < c_SPAN);
  assign w_cpu_idx  = w_cpu_off[c_AW+1:2];
  assign w_load_idx = w_load_off[c_AW+1:2];
  assign w_accept   = bus.inst_sram_en && !reset;

  // Loader owns the single write port whenever it is active, so on a
  // same-word collision every byte comes from the loader.
  always_comb begin
    w_we    = 4'b0000;
    w_waddr = w_cpu_idx;
    w_wdata = bus.inst_sram_wdata;
    if (load_en && w_load_in) begin
      w_we    = 4'b1111;
      w_waddr = w_load_idx;
      w_wdata = load_data;
    end else if (w_accept && w_cpu_in) begin
      w_we    = bus.inst_sram_wen;
    end
  end

  sram_bank #(
    .DEPTH (DEPTH),
    .AW    (c_AW)
  ) u_bank (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_accept && w_cpu_in),
    .i_raddr (w_cpu_idx),
    .o_rdata (w_bank_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src     <= SRC_ZERO;
      r_rvalid  <= 1'b0;
      r_oob_err <= 1'b0;
    end else begin
      r_rvalid  <= w_accept && (bus.inst_sram_wen == 4'b0000);
      r_oob_err <= w_accept && !w_cpu_in;
      if (w_accept) begin
        r_src <= w_cpu_in ? SRC_BANK : SRC_OOB;
      end
    end
  end

  always_comb begin
    bus.inst_sram_rdata = 32'h0;
    case (r_src)
      SRC_BANK: bus.inst_sram_rdata = w_bank_rdata;
      SRC_OOB:  bus.inst_sram_rdata = OOB_INST;
      default:  bus.inst_sram_rdata = 32'h0;
    endcase
  end

  assign bus.inst_sram_rvalid = r_rvalid;
  assign oob_err              = r_oob_err;

endmodule

`default_nettype wire

// File: tb/tb_inst_sram_resp.sv
// ============================================================================
// Module  : tb_inst_sram_resp
// Brief   : Directed self-checking bench for inst_sram_resp.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_inst_sram_resp;

  logic        clk;
  logic        reset;
  logic        oob_err;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  int          n_checks;
  int          n_errors;

  inst_sram_resp_if bus ();

  inst_sram_resp u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .oob_err   (oob_err),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic en, input logic [3:0] wen,
                     input logic [31:0] addr, input logic [31:0] wdata);
    bus.inst_sram_en    = en;
    bus.inst_sram_wen   = wen;
    bus.inst_sram_addr  = addr;
    bus.inst_sram_wdata = wdata;
  endtask

  task automatic ld(input logic en, input logic [31:0] addr, input logic [31:0] data);
    load_en   = en;
    load_addr = addr;
    load_data = data;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    cpu(1'b0, 4'h0, 32'h0, 32'h0);
    ld(1'b0, 32'h0, 32'h0);
    step();

    // T1 preload during reset, then back-to-back reads
    ld(1'b1, 32'h1c000000, 32'h02800421);
    step();
    chk("reset_rdata", bus.inst_sram_rdata, 32'h0);
    chk("reset_rvalid", 32'(bus.inst_sram_rvalid), 32'h0);
    chk("reset_oob", 32'(oob_err), 32'h0);
    ld(1'b1, 32'h1c000004, 32'h02800842);
    step();
    ld(1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    cpu(1'b1, 4'h0, 32'h1c000000, 32'h0);
    step();
    chk("t1_rdata0", bus.inst_sram_rdata, 32'h02800421);
    chk("t1_rvalid0", 32'(bus.inst_sram_rvalid), 32'h1);
    cpu(1'b1, 4'h0, 32'h1c000004, 32'h0);
    step();
    chk("t1_rdata1", bus.inst_sram_rdata, 32'h02800842);
    chk("t1_rvalid1", 32'(bus.inst_sram_rvalid), 32'h1);

    // T2 idle hold
    cpu(1'b0, 4'h0, 32'h1c000000, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_rdata", bus.inst_sram_rdata, 32'h02800842);
      chk("t2_hold_rvalid", 32'(bus.inst_sram_rvalid), 32'h0);
    end

    // T3 byte-lane write with read-first
    ld(1'b1, 32'h1c000010, 32'h11223344);
    step();
    ld(1'b0, 32'h0, 32'h0);
    cpu(1'b1, 4'b0011, 32'h1c000010, 32'hAABBCCDD);
    step();
    chk("t3_readfirst", bus.inst_sram_rdata, 32'h11223344);
    chk("t3_wr_rvalid", 32'(bus.inst_sram_rvalid), 32'h0);
    cpu(1'b1, 4'h0, 32'h1c000010, 32'h0);
    step();
    chk("t3_merged", bus.inst_sram_rdata, 32'h1122CCDD);

    // T4 out of range, below base and one past the top
    cpu(1'b1, 4'h0, 32'h1bfffffc, 32'h0);
    step();
    chk("t4_oob_rdata", bus.inst_sram_rdata, 32'h03400000);
    chk("t4_oob_err", 32'(oob_err), 32'h1);
    chk("t4_oob_rvalid", 32'(bus.inst_sram_rvalid), 32'h1);
    cpu(1'b0, 4'h0, 32'h0, 32'h0);
    step();
    chk("t4_oob_pulse", 32'(oob_err), 32'h0);
    chk("t4_oob_hold", bus.inst_sram_rdata, 32'h03400000);
    cpu(1'b1, 4'hf, 32'h1c004000, 32'hDEADBEEF);
    step();
    chk("t4_wr_oob_err", 32'(oob_err), 32'h1);
    chk("t4_wr_oob_rvalid", 32'(bus.inst_sram_rvalid), 32'h0);
    cpu(1'b1, 4'h0, 32'h1c000000, 32'h0);
    step();
    chk("t4_no_alias", bus.inst_sram_rdata, 32'h02800421);
    chk("t4_err_clear", 32'(oob_err), 32'h0);

    // Loader ignores out-of-range addresses without raising oob_err
    cpu(1'b0, 4'h0, 32'h0, 32'h0);
    ld(1'b1, 32'h1c004000, 32'h76543210);
    step();
    chk("ld_oob_noerr", 32'(oob_err), 32'h0);
    ld(1'b0, 32'h0, 32'h0);
    cpu(1'b1, 4'h0, 32'h1c000000, 32'h0);
    step();
    chk("ld_oob_noalias", bus.inst_sram_rdata, 32'h02800421);

    // T5 load/CPU write collision
    cpu(1'b0, 4'h0, 32'h0, 32'h0);
    ld(1'b1, 32'h1c000020, 32'h55555555);
    step();
    ld(1'b1, 32'h1c000020, 32'hCAFEF00D);
    cpu(1'b1, 4'hf, 32'h1c000020, 32'h12345678);
    step();
    chk("t5_old_word", bus.inst_sram_rdata, 32'h55555555);
    ld(1'b0, 32'h0, 32'h0);
    cpu(1'b1, 4'h0, 32'h1c000020, 32'h0);
    step();
    chk("t5_load_wins", bus.inst_sram_rdata, 32'hCAFEF00D);

    // T6 reset mid-stream
    cpu(1'b1, 4'h0, 32'h1c000004, 32'h0);
    step();
    chk("t6_pre", bus.inst_sram_rdata, 32'h02800842);
    reset = 1'b1;
    cpu(1'b1, 4'h0, 32'h1c000000, 32'h0);
    step();
    chk("t6_rst_rdata", bus.inst_sram_rdata, 32'h0);
    chk("t6_rst_rvalid", 32'(bus.inst_sram_rvalid), 32'h0);
    reset = 1'b0;
    cpu(1'b1, 4'h0, 32'h1c000010, 32'h0);
    step();
    chk("t6_post0", bus.inst_sram_rdata, 32'h1122CCDD);
    chk("t6_post_rvalid", 32'(bus.inst_sram_rvalid), 32'h1);
    cpu(1'b1, 4'h0, 32'h1c000000, 32'h0);
    step();
    chk("t6_post1", bus.inst_sram_rdata, 32'h02800421);
    cpu(1'b0, 4'h0, 32'h0, 32'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
